data_mem_controller: RTL and testbench

//  Responder side of the MEM-stage data-memory interface. Accepts one read or write request per

---
 rtl/data_mem_controller_pkg.sv | 16 +
 rtl/data_mem_controller_mem_wait_counter.sv | 39 +++
 rtl/data_mem_controller.sv | 137 +++++++++++++
 tb/tb_data_mem_controller.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_controller_pkg.sv
// Shared definitions for the MEM-stage data-memory controller: FSM encoding and
// default parameter values.
package data_mem_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOW  = 2'd1,
      ST_HIGH = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   localparam logic [31:0] BASE_ADDR_DEFAULT   = 32'd1024;
   localparam int          ADDR_W_DEFAULT      = 16;
   localparam int          WAIT_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/data_mem_controller_mem_wait_counter.sv
// Wait-state counter for one half-word SRAM phase; flags the phase's last cycle
// and saturates there until cleared.
module mem_wait_counter #(
   parameter int WAIT_CYCLES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   input  logic enable_i,
   output logic tc_o
);

   localparam int                CNT_W    = $clog2(WAIT_CYCLES + 1);
   localparam logic [CNT_W-1:0]  TERMINAL = CNT_W'(WAIT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign tc_o = (cnt_q == TERMINAL);

   // NOTE: every variable written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (enable_i && !tc_o) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together at the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/data_mem_controller.sv
// Responder for MEM-stage loads/stores: splits each 32-bit access into two wait-stated
// half-word accesses on a 16-bit SRAM and freezes the pipeline until it completes.
module data_mem_controller
   import data_mem_controller_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int          ADDR_W      = ADDR_W_DEFAULT,
   parameter int          WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_r_en,
   input  logic              mem_w_en,
   input  logic [31:0]       address,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic              freeze,
   output logic [ADDR_W:0]   sram_addr,
   output logic [15:0]       sram_wdata,
   input  logic [15:0]       sram_rdata,
   output logic              sram_we_n,
   output logic              sram_oe_n
);

   mem_state_e        state_q, state_d;
   logic              op_wr_q, op_wr_d;
   logic [ADDR_W-1:0] word_q, word_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [31:0]       rdata_q, rdata_d;
   logic [ADDR_W:0]   sram_addr_q, sram_addr_d;
   logic [15:0]       sram_wdata_q, sram_wdata_d;
   logic              sram_we_n_q, sram_we_n_d;
   logic              sram_oe_n_q, sram_oe_n_d;

   logic              req;
   logic [31:0]       addr_off;
   logic [ADDR_W-1:0] word_in;
   logic              addr_bits_unused;
   logic              in_phase;
   logic              tc;

   assign req      = mem_r_en | mem_w_en;
   assign addr_off = address - BASE_ADDR;
   assign word_in  = addr_off[ADDR_W+1:2];
   // Byte offset and out-of-range word bits are deliberately dropped (address wraps).
   assign addr_bits_unused = ^{addr_off[31:ADDR_W+2], addr_off[1:0]};

   assign in_phase = (state_q == ST_LOW) || (state_q == ST_HIGH);

   mem_wait_counter #(
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .clear_i  (!in_phase || tc),
      .enable_i (in_phase),
      .tc_o     (tc)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         op_wr_q      <= 1'b0;
         word_q       <= '0;
         wdata_q      <= '0;
         rdata_q      <= '0;
         sram_addr_q  <= '0;
         sram_wdata_q <= '0;
         sram_we_n_q  <= 1'b1;
         sram_oe_n_q  <= 1'b1;
      end else begin
         state_q      <= state_d;
         op_wr_q      <= op_wr_d;
         word_q       <= word_d;
         wdata_q      <= wdata_d;
         rdata_q      <= rdata_d;
         sram_addr_q  <= sram_addr_d;
         sram_wdata_q <= sram_wdata_d;
         sram_we_n_q  <= sram_we_n_d;
         sram_oe_n_q  <= sram_oe_n_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (req) state_d = ST_LOW;
         ST_LOW:  if (tc)  state_d = ST_HIGH;
         ST_HIGH: if (tc)  state_d = ST_DONE;
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // SRAM pins are registered, so they are computed from the state being entered.
   always_comb begin
      op_wr_d      = op_wr_q;
      word_d       = word_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      sram_addr_d  = sram_addr_q;
      sram_wdata_d = sram_wdata_q;
      sram_we_n_d  = 1'b1;
      sram_oe_n_d  = 1'b1;
      ready        = (state_q == ST_DONE) || ((state_q == ST_IDLE) && !req);

      if ((state_q == ST_IDLE) && req) begin
         op_wr_d = mem_w_en;
         word_d  = word_in;
         wdata_d = wdata;
      end

      if (!op_wr_q && tc) begin
         if (state_q == ST_LOW)  rdata_d[15:0]  = sram_rdata;
         if (state_q == ST_HIGH) rdata_d[31:16] = sram_rdata;
      end

      if ((state_d == ST_LOW) || (state_d == ST_HIGH)) begin
         sram_addr_d = {word_d, state_d == ST_HIGH};
         if (op_wr_d) begin
            sram_we_n_d  = 1'b0;
            sram_wdata_d = (state_d == ST_HIGH) ? wdata_d[31:16] : wdata_d[15:0];
         end else begin
            sram_oe_n_d = 1'b0;
         end
      end
   end

   assign freeze     = ~ready;
   assign rdata      = rdata_q;
   assign sram_addr  = sram_addr_q;
   assign sram_wdata = sram_wdata_q;
   assign sram_we_n  = sram_we_n_q;
   assign sram_oe_n  = sram_oe_n_q;

endmodule

// File: tb/tb_data_mem_controller.sv
// Randomized bench for data_mem_controller: a behavioural SRAM plus a word-level
// reference memory that predicts pin activity, latency and load data.
module tb_data_mem_controller;

   localparam int          ADDR_W      = 16;
   localparam int          WAIT_CYCLES = 2;
   localparam logic [31:0] BASE_ADDR   = 32'd1024;
   localparam int          LATENCY     = 2 * WAIT_CYCLES + 1;

   logic              clk;
   logic              rst;
   logic              mem_r_en;
   logic              mem_w_en;
   logic [31:0]       address;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic              ready;
   logic              freeze;
   logic [ADDR_W:0]   sram_addr;
   logic [15:0]       sram_wdata;
   logic [15:0]       sram_rdata;
   logic              sram_we_n;
   logic              sram_oe_n;

   logic [15:0]       sram_mem [0:(1 << (ADDR_W + 1)) - 1];
   logic [31:0]       ref_words [int];
   int                written_q [$];

   int n_checks = 0;
   int n_pass   = 0;

   data_mem_controller #(
      .BASE_ADDR   (BASE_ADDR),
      .ADDR_W      (ADDR_W),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .mem_r_en   (mem_r_en),
      .mem_w_en   (mem_w_en),
      .address    (address),
      .wdata      (wdata),
      .rdata      (rdata),
      .ready      (ready),
      .freeze     (freeze),
      .sram_addr  (sram_addr),
      .sram_wdata (sram_wdata),
      .sram_rdata (sram_rdata),
      .sram_we_n  (sram_we_n),
      .sram_oe_n  (sram_oe_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural 16-bit SRAM: synchronous write, registered read while oe_n is low.
   always @(posedge clk) begin
      if (!sram_we_n) sram_mem[sram_addr] <= sram_wdata;
      if (!sram_oe_n) sram_rdata <= sram_mem[sram_addr];
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   function automatic int word_of(input logic [31:0] addr);
      logic [31:0] off;
      off = addr - BASE_ADDR;
      return int'((off / 32'd4) % (32'd1 << ADDR_W));
   endfunction

   function automatic logic [31:0] addr_for(input int w);
      logic [31:0] a;
      a = BASE_ADDR + 32'(w) * 32'd4 + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) a = a + (32'd1 << (ADDR_W + 2));
      return a;
   endfunction

   // One complete access starting from IDLE; returns at the DONE cycle.
   task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] data);
      int          w;
      int          cyc;
      bit          done;
      logic        phase_high;
      logic [31:0] exp_addr;
      w = word_of(addr);
      @(negedge clk);
      check("idle_ready", ready, 1'b1);
      mem_r_en = rd;
      mem_w_en = wr;
      address  = addr;
      wdata    = data;
      #1;
      check("req_freeze", freeze, 1'b1);
      cyc  = 0;
      done = 0;
      while (!done && cyc < 50) begin
         @(negedge clk);
         cyc++;
         if (ready) begin
            done = 1;
         end else if (cyc <= 2 * WAIT_CYCLES) begin
            phase_high = (cyc > WAIT_CYCLES);
            exp_addr   = 32'(w) * 32'd2 + 32'(phase_high);
            check("sram_addr", 32'(sram_addr), exp_addr);
            check("we_n", sram_we_n, !wr);
            check("oe_n", sram_oe_n, wr);
            if (wr) check("sram_wdata", sram_wdata, phase_high ? data[31:16] : data[15:0]);
         end
      end
      check("latency", 32'(cyc), 32'(LATENCY));
      check("done_freeze", freeze, 1'b0);
      check("done_we_n", sram_we_n, 1'b1);
      check("done_oe_n", sram_oe_n, 1'b1);
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      if (wr) begin
         if (!ref_words.exists(w)) written_q.push_back(w);
         ref_words[w] = data;
         check("sram_lo", sram_mem[2 * w],     ref_words[w][15:0]);
         check("sram_hi", sram_mem[2 * w + 1], ref_words[w][31:16]);
      end else begin
         check("rdata", rdata, ref_words[w]);
      end
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int w;
      rst      = 1'b1;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      address  = '0;
      wdata    = '0;
      repeat (2) @(negedge clk);
      check("rst_ready", ready, 1'b1);
      check("rst_freeze", freeze, 1'b0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_we_n", sram_we_n, 1'b1);
      check("rst_oe_n", sram_oe_n, 1'b1);
      check("rst_addr", 32'(sram_addr), 32'h0);
      check("rst_wdata", sram_wdata, 16'h0);
      rst = 1'b0;

      // Reset during the LOW phase of a write; word 7 is left undefined and never read.
      @(negedge clk);
      mem_w_en = 1'b1;
      address  = BASE_ADDR + 32'd28;
      wdata    = 32'hCAFE_F00D;
      repeat (2) @(negedge clk);
      check("midwr_we_n", sram_we_n, 1'b0);
      rst      = 1'b1;
      mem_w_en = 1'b0;
      @(negedge clk);
      check("abort_freeze", freeze, 1'b0);
      check("abort_we_n", sram_we_n, 1'b1);
      @(negedge clk);
      rst = 1'b0;

      access(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
      check("t2_sram0", sram_mem[0], 16'hBEEF);
      check("t2_sram1", sram_mem[1], 16'hDEAD);
      access(1'b1, 1'b0, 32'd1024, 32'h0);
      check("t3_rdata", rdata, 32'hDEAD_BEEF);
      access(1'b0, 1'b1, 32'd1028, 32'h1234_5678);
      access(1'b1, 1'b0, 32'd1028, 32'h0);
      check("t4_rdata", rdata, 32'h1234_5678);
      access(1'b1, 1'b1, 32'd1032, 32'hA5A5_5A5A);
      check("t5_sram4", sram_mem[4], 16'h5A5A);
      check("t5_sram5", sram_mem[5], 16'hA5A5);
      access(1'b1, 1'b0, BASE_ADDR + (32'd1 << (ADDR_W + 2)), 32'h0);
      check("t6_wrap", rdata, 32'hDEAD_BEEF);
      repeat (2) begin
         @(negedge clk);
         check("t6_idle_ready", ready, 1'b1);
         check("t6_idle_freeze", freeze, 1'b0);
      end

      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) begin
            @(negedge clk);
            check("gap_ready", ready, 1'b1);
         end
         if ($urandom_range(0, 1) == 1) begin
            w = $urandom_range(16, 4095);
            access(($urandom_range(0, 3) == 0), 1'b1, addr_for(w), $urandom);
         end else begin
            w = written_q[$urandom_range(0, written_q.size() - 1)];
            access(1'b1, 1'b0, addr_for(w), $urandom);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
